star_route: RTL and testbench

- Chained AXI-Stream router stage; the receiving-side counterpart of the star-token arbiter chain.
- Accepts a merged packet stream on `in_*` and inspects the first beat of each packet.
- Packets whose address field equals MY_ADDR are delivered whole to the local port `loc_*`; all others are forwarded whole to the next stage on `nxt_*`.
- N stages in series fan one stream out to N sinks; the last stage's `nxt_*` may be tied off with `nxt_TREADY=1` as a discard path.

---
 rtl/star_pkg.sv | 30 +++
 rtl/axis_reg_slice.sv | 40 ++++
 rtl/star_route.sv | 109 ++++++++++
 tb/tb_star_route.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/star_pkg.sv
// Shared encodings for the star-token router chain: FSM states, route select, header width.
package star_pkg;

    localparam logic [1:0] ST_HEAD  = 2'd0;
    localparam logic [1:0] ST_LOCAL = 2'd1;
    localparam logic [1:0] ST_PASS  = 2'd2;

    localparam logic SEL_LOC = 1'b0;
    localparam logic SEL_NXT = 1'b1;

    localparam int HDR_ADDR_WIDTH = 2;

    // Next route state for an accepted beat; TLAST always closes the packet.
    function automatic logic [1:0] next_state(input logic [1:0] st,
                                              input logic       sel,
                                              input logic       last);
        logic [1:0] ns;
        ns = ST_HEAD;
        if (!last) begin
            case (st)
                ST_HEAD:  ns = (sel == SEL_LOC) ? ST_LOCAL : ST_PASS;
                ST_LOCAL: ns = ST_LOCAL;
                ST_PASS:  ns = ST_PASS;
                default:  ns = ST_HEAD;
            endcase
        end
        return ns;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry AXI-Stream register slice; refills in the same cycle it drains.
module axis_reg_slice #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_last,
    input  logic                  i_ready
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;

    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/star_route.sv
// Chained AXI-Stream router stage: header address selects local sink or next stage.
// Optional STAR_ROUTE_CNT_EN adds per-output completed-packet counters.
module star_route
    import star_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = HDR_ADDR_WIDTH,
    parameter int MY_ADDR    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_TDATA,
    input  logic                  in_TVALID,
    output logic                  in_TREADY,
    input  logic                  in_TLAST,
    output logic [DATA_WIDTH-1:0] loc_TDATA,
    output logic                  loc_TVALID,
    input  logic                  loc_TREADY,
    output logic                  loc_TLAST,
    output logic [DATA_WIDTH-1:0] nxt_TDATA,
    output logic                  nxt_TVALID,
    input  logic                  nxt_TREADY,
    output logic                  nxt_TLAST
`ifdef STAR_ROUTE_CNT_EN
    ,
    output logic [15:0]           loc_pkt_cnt,
    output logic [15:0]           nxt_pkt_cnt
`endif
);

    logic [1:0] r_state;
    logic       w_sel;
    logic       w_hdr_match;
    logic       w_loc_ready;
    logic       w_nxt_ready;
    logic       w_accept;
    logic       w_loc_load;
    logic       w_nxt_load;

    assign w_hdr_match = (in_TDATA[ADDR_WIDTH-1:0] == ADDR_WIDTH'(MY_ADDR));

    // Route is latched at the header; body beats never re-evaluate the address.
    always_comb begin
        w_sel = SEL_NXT;
        case (r_state)
            ST_LOCAL: w_sel = SEL_LOC;
            ST_PASS:  w_sel = SEL_NXT;
            default:  w_sel = w_hdr_match ? SEL_LOC : SEL_NXT;
        endcase
    end

    assign in_TREADY  = (w_sel == SEL_LOC) ? w_loc_ready : w_nxt_ready;
    assign w_accept   = in_TVALID && in_TREADY && !rst;
    assign w_loc_load = w_accept && (w_sel == SEL_LOC);
    assign w_nxt_load = w_accept && (w_sel == SEL_NXT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HEAD;
        end else if (w_accept) begin
            r_state <= next_state(r_state, w_sel, in_TLAST);
        end
    end

    axis_reg_slice #(.DATA_WIDTH(DATA_WIDTH)) u_loc_slice (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_loc_load),
        .i_data  (in_TDATA),
        .i_last  (in_TLAST),
        .o_ready (w_loc_ready),
        .o_data  (loc_TDATA),
        .o_valid (loc_TVALID),
        .o_last  (loc_TLAST),
        .i_ready (loc_TREADY)
    );

    axis_reg_slice #(.DATA_WIDTH(DATA_WIDTH)) u_nxt_slice (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_nxt_load),
        .i_data  (in_TDATA),
        .i_last  (in_TLAST),
        .o_ready (w_nxt_ready),
        .o_data  (nxt_TDATA),
        .o_valid (nxt_TVALID),
        .o_last  (nxt_TLAST),
        .i_ready (nxt_TREADY)
    );

`ifdef STAR_ROUTE_CNT_EN
    logic [15:0] r_loc_cnt;
    logic [15:0] r_nxt_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_loc_cnt <= '0;
            r_nxt_cnt <= '0;
        end else begin
            if (loc_TVALID && loc_TREADY && loc_TLAST) r_loc_cnt <= r_loc_cnt + 16'd1;
            if (nxt_TVALID && nxt_TREADY && nxt_TLAST) r_nxt_cnt <= r_nxt_cnt + 16'd1;
        end
    end

    assign loc_pkt_cnt = r_loc_cnt;
    assign nxt_pkt_cnt = r_nxt_cnt;
`endif

endmodule

// File: tb/tb_star_route.sv
// Directed vector table against a MY_ADDR=1 stage, then a randomized 3-stage chain with scoreboard.
module tb_star_route;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- single stage, MY_ADDR=1 ----------------
    logic [7:0] in_d = '0;
    logic       in_v = 1'b0, in_l = 1'b0, in_r;
    logic [7:0] ld, nd;
    logic       lv, ll, nv, nl;
    logic       lr = 1'b1, nr = 1'b1;
`ifdef STAR_ROUTE_CNT_EN
    logic [15:0] cnt_a, cnt_b, cnt_c [6];
`endif

    star_route #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .MY_ADDR(1)) dut (
        .clk(clk), .rst(rst),
        .in_TDATA(in_d), .in_TVALID(in_v), .in_TREADY(in_r), .in_TLAST(in_l),
        .loc_TDATA(ld), .loc_TVALID(lv), .loc_TREADY(lr), .loc_TLAST(ll),
        .nxt_TDATA(nd), .nxt_TVALID(nv), .nxt_TREADY(nr), .nxt_TLAST(nl)
`ifdef STAR_ROUTE_CNT_EN
        , .loc_pkt_cnt(cnt_a), .nxt_pkt_cnt(cnt_b)
`endif
    );

    // ---------------- 3-stage chain, MY_ADDR=0,1,2 ----------------
    logic [7:0] s_d = '0;
    logic       s_v = 1'b0, s_l = 1'b0, s_r;
    logic [7:0] a_d, b_d;
    logic       a_v, a_r, a_l, b_v, b_r, b_l;
    logic [7:0] k_d [4];
    logic       k_v [4];
    logic       k_l [4];
    logic       k_r [4];

    star_route #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .MY_ADDR(0)) u_c0 (
        .clk(clk), .rst(rst),
        .in_TDATA(s_d), .in_TVALID(s_v), .in_TREADY(s_r), .in_TLAST(s_l),
        .loc_TDATA(k_d[0]), .loc_TVALID(k_v[0]), .loc_TREADY(k_r[0]), .loc_TLAST(k_l[0]),
        .nxt_TDATA(a_d), .nxt_TVALID(a_v), .nxt_TREADY(a_r), .nxt_TLAST(a_l)
`ifdef STAR_ROUTE_CNT_EN
        , .loc_pkt_cnt(cnt_c[0]), .nxt_pkt_cnt(cnt_c[1])
`endif
    );

    star_route #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .MY_ADDR(1)) u_c1 (
        .clk(clk), .rst(rst),
        .in_TDATA(a_d), .in_TVALID(a_v), .in_TREADY(a_r), .in_TLAST(a_l),
        .loc_TDATA(k_d[1]), .loc_TVALID(k_v[1]), .loc_TREADY(k_r[1]), .loc_TLAST(k_l[1]),
        .nxt_TDATA(b_d), .nxt_TVALID(b_v), .nxt_TREADY(b_r), .nxt_TLAST(b_l)
`ifdef STAR_ROUTE_CNT_EN
        , .loc_pkt_cnt(cnt_c[2]), .nxt_pkt_cnt(cnt_c[3])
`endif
    );

    star_route #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .MY_ADDR(2)) u_c2 (
        .clk(clk), .rst(rst),
        .in_TDATA(b_d), .in_TVALID(b_v), .in_TREADY(b_r), .in_TLAST(b_l),
        .loc_TDATA(k_d[2]), .loc_TVALID(k_v[2]), .loc_TREADY(k_r[2]), .loc_TLAST(k_l[2]),
        .nxt_TDATA(k_d[3]), .nxt_TVALID(k_v[3]), .nxt_TREADY(k_r[3]), .nxt_TLAST(k_l[3])
`ifdef STAR_ROUTE_CNT_EN
        , .loc_pkt_cnt(cnt_c[4]), .nxt_pkt_cnt(cnt_c[5])
`endif
    );

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       l, lr, nr;
        logic       rdy;
        logic       lv;
        logic [7:0] ld;
        logic       ll, nv;
        logic [7:0] nd;
        logic       nl;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l,
                                input logic lr_i, input logic nr_i, input logic rdy,
                                input logic lv_e, input logic [7:0] ld_e, input logic ll_e,
                                input logic nv_e, input logic [7:0] nd_e, input logic nl_e);
        vec_t t;
        t.v = v; t.d = d; t.l = l; t.lr = lr_i; t.nr = nr_i; t.rdy = rdy;
        t.lv = lv_e; t.ld = ld_e; t.ll = ll_e; t.nv = nv_e; t.nd = nd_e; t.nl = nl_e;
        return t;
    endfunction

    // Chain scoreboard: one expected queue per sink, entries are {last, data}.
    logic [8:0] q0[$], q1[$], q2[$], q3[$];
    int unsigned beats_left = 0;
    logic [5:0]  seq = '0;
    logic [1:0]  cur_addr = '0;
    logic        src_acc = 1'b0;
    int          received = 0;

    task automatic push(input int a, input logic [8:0] x);
        case (a)
            0: q0.push_back(x);
            1: q1.push_back(x);
            2: q2.push_back(x);
            default: q3.push_back(x);
        endcase
    endtask

    function automatic int qsize(input int s);
        case (s)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic pop_chk(input int s, input logic [7:0] d, input logic l);
        logic [8:0] e;
        if (qsize(s) == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sink%0d_unexpected: got 0x%0h expected no beat at %0t", s, {l, d}, $time);
        end else begin
            case (s)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                2: e = q2.pop_front();
                default: e = q3.pop_front();
            endcase
            chk($sformatf("sink%0d_beat", s), int'({l, d}), int'(e));
        end
    endtask

    task automatic chain_cycle(input bit gen_new, input bit rand_rdy);
        @(negedge clk);
        if (src_acc) s_v = 1'b0;
        src_acc = 1'b0;
        for (int i = 0; i < 4; i++) k_r[i] = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (!s_v) begin
            if (beats_left == 0 && gen_new && $urandom_range(0, 2) != 0) begin
                cur_addr   = 2'($urandom_range(0, 3));
                beats_left = $urandom_range(1, 4);
                seq        = seq + 6'd1;
                s_d        = {seq, cur_addr};
                s_l        = (beats_left == 1);
                s_v        = 1'b1;
            end else if (beats_left != 0 && $urandom_range(0, 3) != 0) begin
                s_d = 8'($urandom_range(0, 255));
                s_l = (beats_left == 1);
                s_v = 1'b1;
            end
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            if (k_v[i] && k_r[i]) begin
                pop_chk(i, k_d[i], k_l[i]);
                received++;
            end
        end
        if (s_v && s_r) begin
            push(int'(cur_addr), {s_l, s_d});
            beats_left--;
            src_acc = 1'b1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    vec_t tbl [31];

    initial begin
        for (int i = 0; i < 4; i++) k_r[i] = 1'b1;

        tbl[0]  = mk(1, 8'h05, 0, 1, 1, 1,  0, 8'h00, 0,  0, 8'h00, 0);
        tbl[1]  = mk(1, 8'h09, 1, 1, 1, 1,  1, 8'h05, 0,  0, 8'h00, 0);
        tbl[2]  = mk(1, 8'h04, 0, 1, 1, 1,  1, 8'h09, 1,  0, 8'h00, 0);
        tbl[3]  = mk(1, 8'h08, 1, 1, 1, 1,  0, 8'h00, 0,  1, 8'h04, 0);
        tbl[4]  = mk(0, 8'h00, 0, 1, 1, 1,  0, 8'h00, 0,  1, 8'h08, 1);
        tbl[5]  = mk(0, 8'h00, 0, 1, 1, 1,  0, 8'h00, 0,  0, 8'h00, 0);
        tbl[6]  = mk(1, 8'h02, 0, 1, 1, 1,  0, 8'h00, 0,  0, 8'h00, 0);
        tbl[7]  = mk(1, 8'h01, 1, 1, 1, 1,  0, 8'h00, 0,  1, 8'h02, 0);
        tbl[8]  = mk(0, 8'h00, 0, 1, 1, 1,  0, 8'h00, 0,  1, 8'h01, 1);
        tbl[9]  = mk(0, 8'h00, 0, 1, 1, 1,  0, 8'h00, 0,  0, 8'h00, 0);
        tbl[10] = mk(1, 8'h01, 1, 1, 1, 1,  0, 8'h00, 0,  0, 8'h00, 0);
        tbl[11] = mk(1, 8'h02, 1, 1, 1, 1,  1, 8'h01, 1,  0, 8'h00, 0);
        tbl[12] = mk(1, 8'h01, 1, 1, 1, 1,  0, 8'h00, 0,  1, 8'h02, 1);
        tbl[13] = mk(1, 8'h02, 1, 1, 1, 1,  1, 8'h01, 1,  0, 8'h00, 0);
        tbl[14] = mk(0, 8'h00, 0, 1, 1, 1,  0, 8'h00, 0,  1, 8'h02, 1);
        tbl[15] = mk(0, 8'h00, 0, 1, 1, 1,  0, 8'h00, 0,  0, 8'h00, 0);
        tbl[16] = mk(1, 8'h00, 1, 0, 1, 1,  0, 8'h00, 0,  0, 8'h00, 0);
        tbl[17] = mk(1, 8'h04, 0, 0, 1, 1,  0, 8'h00, 0,  1, 8'h00, 1);
        tbl[18] = mk(1, 8'h05, 1, 0, 1, 1,  0, 8'h00, 0,  1, 8'h04, 0);
        tbl[19] = mk(1, 8'h01, 1, 0, 1, 1,  0, 8'h00, 0,  1, 8'h05, 1);
        tbl[20] = mk(1, 8'h05, 0, 0, 1, 0,  1, 8'h01, 1,  0, 8'h00, 0);
        tbl[21] = mk(1, 8'h05, 0, 0, 1, 0,  1, 8'h01, 1,  0, 8'h00, 0);
        tbl[22] = mk(1, 8'h05, 0, 1, 1, 1,  1, 8'h01, 1,  0, 8'h00, 0);
        tbl[23] = mk(1, 8'h0A, 1, 1, 1, 1,  1, 8'h05, 0,  0, 8'h00, 0);
        tbl[24] = mk(0, 8'h00, 0, 1, 1, 1,  1, 8'h0A, 1,  0, 8'h00, 0);
        tbl[25] = mk(0, 8'h00, 0, 1, 1, 1,  0, 8'h00, 0,  0, 8'h00, 0);
        tbl[26] = mk(1, 8'h00, 1, 1, 0, 1,  0, 8'h00, 0,  0, 8'h00, 0);
        tbl[27] = mk(1, 8'h01, 1, 1, 0, 1,  0, 8'h00, 0,  1, 8'h00, 1);
        tbl[28] = mk(0, 8'h00, 0, 1, 0, 0,  1, 8'h01, 1,  1, 8'h00, 1);
        tbl[29] = mk(0, 8'h00, 0, 1, 1, 1,  0, 8'h00, 0,  1, 8'h00, 1);
        tbl[30] = mk(0, 8'h00, 0, 1, 1, 1,  0, 8'h00, 0,  0, 8'h00, 0);

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_loc_valid", lv, 0);
        chk("rst_nxt_valid", nv, 0);
        chk("rst_loc_data", ld, 0);
        chk("rst_nxt_data", nd, 0);
        chk("rst_loc_last", ll, 0);
        chk("rst_nxt_last", nl, 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            in_v = tbl[i].v; in_d = tbl[i].d; in_l = tbl[i].l;
            lr = tbl[i].lr; nr = tbl[i].nr;
            #1;
            chk($sformatf("v%0d_in_ready", i), in_r, tbl[i].rdy);
            chk($sformatf("v%0d_loc_valid", i), lv, tbl[i].lv);
            chk($sformatf("v%0d_nxt_valid", i), nv, tbl[i].nv);
            if (tbl[i].lv) begin
                chk($sformatf("v%0d_loc_data", i), ld, tbl[i].ld);
                chk($sformatf("v%0d_loc_last", i), ll, tbl[i].ll);
            end
            if (tbl[i].nv) begin
                chk($sformatf("v%0d_nxt_data", i), nd, tbl[i].nd);
                chk($sformatf("v%0d_nxt_last", i), nl, tbl[i].nl);
            end
        end

        // Reset after the first beat of a 3-beat local packet
        @(negedge clk);
        in_v = 1'b1; in_d = 8'h01; in_l = 1'b0; lr = 1'b0; nr = 1'b1;
        #1 chk("mrst_hdr_ready", in_r, 1);
        @(negedge clk);
        rst = 1'b1; in_d = 8'h02;
        #1;
        chk("mrst_loc_held", lv, 1);
        chk("mrst_loc_data", ld, 8'h01);
        @(negedge clk);
        rst = 1'b0; in_v = 1'b0; in_d = 8'h00; lr = 1'b1;
        #1;
        chk("mrst_loc_cleared", lv, 0);
        chk("mrst_nxt_cleared", nv, 0);
        @(negedge clk);
        in_v = 1'b1; in_d = 8'h00; in_l = 1'b1;
        #1 chk("mrst_new_hdr_ready", in_r, 1);
        @(negedge clk);
        in_v = 1'b0; in_l = 1'b0;
        #1;
        chk("mrst_new_hdr_nxt_valid", nv, 1);
        chk("mrst_new_hdr_nxt_data", nd, 8'h00);
        chk("mrst_new_hdr_nxt_last", nl, 1);
        chk("mrst_new_hdr_loc_valid", lv, 0);
        @(negedge clk);
        #1;
        chk("mrst_idle_nxt_valid", nv, 0);
        chk("mrst_idle_loc_valid", lv, 0);

        // Random chain traffic, then drain with all sinks ready
        for (int c = 0; c < 600; c++) chain_cycle(1'b1, 1'b1);
        for (int c = 0; c < 300; c++) begin
            if (beats_left == 0 && !s_v && q0.size() == 0 && q1.size() == 0 &&
                q2.size() == 0 && q3.size() == 0) break;
            chain_cycle(1'b0, 1'b0);
        end
        for (int s = 0; s < 4; s++) chk($sformatf("chain_sink%0d_drained", s), qsize(s), 0);
        chk("chain_src_done", int'(beats_left), 0);
        chk("chain_traffic_seen", int'(received > 100), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
